// File: rtl/gravity_tick_gen.sv
// gravity_tick_gen
// Programmable tick generator for gravity, auto-repeat and UI blink timing.
// The tick period is BASE_PERIOD << rate_sel, saturated to the counter range.
// A soft-drop override can shorten the period. The block runs one-shot or
// periodic, and keeps a wrapping count of ticks.
//
// Ports
//   clock50M_i    system clock, rising edge
//   clear_i       synchronous active-high reset
//   enable_i      count enable; low pauses the countdown
//   start_i       (re)load the counter and enter RUN
//   stop_i        return to IDLE (wins over start_i)
//   one_shot_i    sampled on start_i: stop after the first tick
//   rate_sel_i    normal period select
//   fast_i        soft-drop override
//   tick_o        registered single-cycle tick pulse
//   busy_o        high while in RUN
//   tick_count_o  ticks since clear, wraps
//   period_o      current effective period (combinational)
//
// state | meaning
// IDLE  | counter held, no ticks
// RUN   | counting down, tick at terminal count then reload

module gravity_tick_gen #(
    parameter int CNT_W       = 32,
    parameter int BASE_PERIOD = 12500000,
    parameter int FAST_PERIOD = 2500000,
    parameter int SEL_W       = 3,
    parameter int TCNT_W      = 8
) (
    input  logic              clock50M_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              one_shot_i,
    input  logic [SEL_W-1:0]  rate_sel_i,
    input  logic              fast_i,
    output logic              tick_o,
    output logic              busy_o,
    output logic [TCNT_W-1:0] tick_count_o,
    output logic [CNT_W-1:0]  period_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Wide enough that the largest shift of a CNT_W-bit base cannot overflow.
    localparam int PW = CNT_W + (1 << SEL_W);

    localparam logic [PW-1:0]    FAST_WIDE = PW'(FAST_PERIOD);
    localparam logic [CNT_W-1:0] FAST_SAT  = (|FAST_WIDE[PW-1:CNT_W]) ?
                                             {CNT_W{1'b1}} : FAST_WIDE[CNT_W-1:0];

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic                mode_os_q;
    logic                tick_q;
    logic [TCNT_W-1:0]   tick_cnt_q;
    logic                fast_q;

    logic [PW-1:0]       p_norm_wide;
    logic [CNT_W-1:0]    p_norm;
    logic [CNT_W-1:0]    period_w;
    logic [CNT_W-1:0]    load_d;
    logic                fast_rise;

    assign p_norm_wide = PW'(BASE_PERIOD) << rate_sel_i;
    assign p_norm      = (|p_norm_wide[PW-1:CNT_W]) ? {CNT_W{1'b1}}
                                                    : p_norm_wide[CNT_W-1:0];
    assign period_w    = (fast_i && (FAST_SAT < p_norm)) ? FAST_SAT : p_norm;
    // Both periods are at least 1, so this cannot underflow.
    assign load_d      = period_w - 1'b1;
    assign fast_rise   = fast_i && !fast_q;

    always_ff @(posedge clock50M_i) begin
        if (clear_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mode_os_q  <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
            fast_q     <= 1'b0;
        end else begin
            fast_q <= fast_i;
            tick_q <= 1'b0;
            if (stop_i) begin
                state_q <= S_IDLE;
            end else if (start_i) begin
                state_q   <= S_RUN;
                count_q   <= load_d;
                mode_os_q <= one_shot_i;
            end else if (state_q == S_RUN) begin
                if (fast_rise) begin
                    // Soft-drop only shortens the period in flight.
                    if (load_d < count_q) begin
                        count_q <= load_d;
                    end
                end else if (enable_i) begin
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end else begin
                        tick_q     <= 1'b1;
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        count_q    <= load_d;
                        if (mode_os_q) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
            end
        end
    end

    assign tick_o       = tick_q;
    assign busy_o       = (state_q == S_RUN);
    assign tick_count_o = tick_cnt_q;
    assign period_o     = period_w;

endmodule

// File: tb/tb_gravity_tick_gen.sv
module tb_gravity_tick_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear, enable, start, stop, one_shot, fast;
    logic [1:0] rate_sel;

    logic       tick_a, busy_a, tick_b, busy_b;
    logic [1:0] tcnt_a, tcnt_b;
    logic [7:0] per_a, per_b;

    gravity_tick_gen #(.CNT_W(8), .BASE_PERIOD(4), .FAST_PERIOD(2), .SEL_W(2), .TCNT_W(2)) dut_a (
        .clock50M_i(clk), .clear_i(clear), .enable_i(enable), .start_i(start),
        .stop_i(stop), .one_shot_i(one_shot), .rate_sel_i(rate_sel), .fast_i(fast),
        .tick_o(tick_a), .busy_o(busy_a), .tick_count_o(tcnt_a), .period_o(per_a));

    gravity_tick_gen #(.CNT_W(8), .BASE_PERIOD(100), .FAST_PERIOD(2), .SEL_W(2), .TCNT_W(2)) dut_b (
        .clock50M_i(clk), .clear_i(clear), .enable_i(enable), .start_i(start),
        .stop_i(stop), .one_shot_i(one_shot), .rate_sel_i(rate_sel), .fast_i(fast),
        .tick_o(tick_b), .busy_o(busy_b), .tick_count_o(tcnt_b), .period_o(per_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one set of inputs and wait for the following falling edge.
    task automatic cyc(input logic c, input logic en, input logic st, input logic sp,
                       input logic os, input logic [1:0] rs, input logic f);
        clear = c; enable = en; start = st; stop = sp;
        one_shot = os; rate_sel = rs; fast = f;
        @(negedge clk);
    endtask

    // Reference model: effective period from plain arithmetic.
    function automatic int mper(input int base, input int rs, input logic f);
        longint p;
        p = longint'(base) * (longint'(1) << rs);
        if (p > 255) p = 255;
        if (f && (p > 2)) p = 2;
        return int'(p);
    endfunction

    // Reference model state per instance: rem = enabled edges left until tick.
    int m_rem[2], m_busy[2], m_os[2], m_tick[2], m_tcnt[2];
    int m_fastq = 0;
    int m_p;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_p = mper((i == 0) ? 4 : 100, int'(rate_sel), fast);
            if (clear) begin
                m_rem[i] = 1; m_busy[i] = 0; m_os[i] = 0; m_tick[i] = 0; m_tcnt[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (stop) begin
                    m_busy[i] = 0;
                end else if (start) begin
                    m_busy[i] = 1; m_rem[i] = m_p; m_os[i] = int'(one_shot);
                end else if (m_busy[i] == 1) begin
                    if (fast && m_fastq == 0) begin
                        if (m_p < m_rem[i]) m_rem[i] = m_p;
                    end else if (enable) begin
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) begin
                            m_tick[i] = 1;
                            m_tcnt[i] = (m_tcnt[i] + 1) % 4;
                            m_rem[i]  = m_p;
                            if (m_os[i] == 1) m_busy[i] = 0;
                        end
                    end
                end
            end
        end
        m_fastq = clear ? 0 : int'(fast);
    end

    typedef struct {
        logic c, en, st, sp, os;
        logic [1:0] rs;
        logic f;
        int e_tick, e_busy, e_tcnt, e_pa, e_pb;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mkv(input logic c, input logic en, input logic st, input logic sp,
                                 input logic os, input logic [1:0] rs, input logic f,
                                 input int et, input int eb, input int ec, input int pa, input int pb);
        vec_t v;
        v.c = c; v.en = en; v.st = st; v.sp = sp; v.os = os; v.rs = rs; v.f = f;
        v.e_tick = et; v.e_busy = eb; v.e_tcnt = ec; v.e_pa = pa; v.e_pb = pb;
        return v;
    endfunction

    initial begin
        int n_tk, first_tk, second_tk, pb;
        logic f, os, en, c, st, sp;
        logic [1:0] rs;

        // Periodic run at P=4, tick after every 4th edge, count wraps at 4.
        tbl[0] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 100);
        tbl[1] = mkv(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4, 100);
        for (int k = 1; k <= 20; k++)
            tbl[1 + k] = mkv(0, 1, 0, 0, 0, 0, 0, (k % 4 == 0) ? 1 : 0, 1, (k / 4) % 4, 4, 100);
        tbl[22] = mkv(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 4, 100);
        // Period decode while idle, both instances.
        for (int r = 0; r < 4; r++) begin
            for (int fi = 0; fi < 2; fi++) begin
                pb = (100 << r) > 255 ? 255 : (100 << r);
                tbl[23 + r * 2 + fi] = mkv(0, 1, 0, 0, 0, 2'(r), 1'(fi), 0, 0, 1,
                                           (fi == 1) ? 2 : (4 << r), (fi == 1) ? 2 : pb);
            end
        end

        for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].c, tbl[i].en, tbl[i].st, tbl[i].sp, tbl[i].os, tbl[i].rs, tbl[i].f);
            chk($sformatf("tbl%0d_tick", i), int'(tick_a), tbl[i].e_tick);
            chk($sformatf("tbl%0d_busy", i), int'(busy_a), tbl[i].e_busy);
            chk($sformatf("tbl%0d_tcnt", i), int'(tcnt_a), tbl[i].e_tcnt);
            chk($sformatf("tbl%0d_per_a", i), int'(per_a), tbl[i].e_pa);
            chk($sformatf("tbl%0d_per_b", i), int'(per_b), tbl[i].e_pb);
        end

        // Pause: P=16 with enable low for edges 6..10 -> tick after edge 21.
        cyc(1, 1, 0, 0, 0, 2, 0);
        cyc(0, 1, 1, 0, 0, 2, 0);
        for (int k = 1; k <= 22; k++) begin
            cyc(0, (k >= 6 && k <= 10) ? 1'b0 : 1'b1, 0, 0, 0, 2, 0);
            chk($sformatf("pause_tick_e%0d", k), int'(tick_a), (k == 21) ? 1 : 0);
        end
        chk("pause_busy", int'(busy_a), 1);

        // Saturated period on the BASE_PERIOD=100 instance.
        cyc(1, 1, 0, 0, 0, 2, 0);
        chk("sat_period", int'(per_b), 255);
        cyc(0, 1, 1, 0, 0, 2, 0);
        n_tk = 0; first_tk = 0; second_tk = 0;
        for (int k = 1; k <= 520; k++) begin
            cyc(0, 1, 0, 0, 0, 2, 0);
            if (tick_b) begin
                n_tk++;
                if (n_tk == 1) first_tk = k;
                if (n_tk == 2) second_tk = k;
            end
        end
        chk("sat_ticks", n_tk, 2);
        chk("sat_first", first_tk, 255);
        chk("sat_second", second_tk, 510);

        // Soft-drop: P=32, fast rises at edge 10, falls at edge 17.
        cyc(1, 1, 0, 0, 0, 3, 0);
        cyc(0, 1, 1, 0, 0, 3, 0);
        for (int k = 1; k <= 52; k++) begin
            cyc(0, 1, 0, 0, 0, 3, (k >= 10 && k <= 16) ? 1'b1 : 1'b0);
            chk($sformatf("fast_tick_e%0d", k), int'(tick_a),
                (k == 12 || k == 14 || k == 16 || k == 18 || k == 50) ? 1 : 0);
            if (k == 10) chk("fast_period_on", int'(per_a), 2);
            if (k == 20) chk("fast_period_off", int'(per_a), 32);
        end

        // One-shot, then start and stop together.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0);
        chk("os_busy_start", int'(busy_a), 1);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk($sformatf("os_tick_e%0d", k), int'(tick_a), (k == 4) ? 1 : 0);
            chk($sformatf("os_busy_e%0d", k), int'(busy_a), (k < 4) ? 1 : 0);
        end
        chk("os_tcnt", int'(tcnt_a), 1);
        cyc(0, 1, 1, 1, 0, 0, 0);
        chk("startstop_busy", int'(busy_a), 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("startstop_tick", int'(tick_a), 0);
            chk("startstop_busy_hold", int'(busy_a), 0);
        end

        // Clear on the edge where a tick would otherwise fire.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) cyc(0, 1, 0, 0, 0, 0, 0);
        chk("clr_pre_tcnt", int'(tcnt_a), 1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("clr_tick", int'(tick_a), 0);
        chk("clr_busy", int'(busy_a), 0);
        chk("clr_tcnt", int'(tcnt_a), 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("clr_no_tick", int'(tick_a), 0);
        end

        // Randomized traffic against the reference model.
        cyc(1, 1, 0, 0, 0, 0, 0);
        f = 1'b0; rs = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            c  = ($urandom_range(0, 199) == 0);
            sp = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 24) == 0);
            en = ($urandom_range(0, 99) < 85);
            os = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) f = ~f;
            if ($urandom_range(0, 29) == 0) rs = 2'($urandom_range(0, 3));
            cyc(c, en, st, sp, os, rs, f);
            chk("rnd_tick_a", int'(tick_a), m_tick[0]);
            chk("rnd_busy_a", int'(busy_a), m_busy[0]);
            chk("rnd_tcnt_a", int'(tcnt_a), m_tcnt[0]);
            chk("rnd_per_a",  int'(per_a),  mper(4, int'(rs), f));
            chk("rnd_tick_b", int'(tick_b), m_tick[1]);
            chk("rnd_busy_b", int'(busy_b), m_busy[1]);
            chk("rnd_tcnt_b", int'(tcnt_b), m_tcnt[1]);
            chk("rnd_per_b",  int'(per_b),  mper(100, int'(rs), f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gravity_tick_gen.md
Name: gravity_tick_gen

Overview:
Parametrised, programmable tick generator that replaces the fixed four-rate 50 MHz divider. It produces single-cycle timing pulses for piece gravity, auto-repeat and UI blinking. Period is BASE_PERIOD shifted left by a rate select, with a soft-drop fast override, one-shot or periodic mode, explicit start/stop, and a wrapping tick counter. One instance is used per timing source in the game top level.

Parameters:
CNT_W, 32, width of the down-counter and of all period arithmetic
BASE_PERIOD, 12500000, period in clocks for rate_sel=0 (0.25 s at 50 MHz); must be >=1
FAST_PERIOD, 2500000, period in clocks while fast=1 (50 ms); must be >=1
SEL_W, 3, width of rate_sel
TCNT_W, 8, width of tick_count

Ports:
clock50M  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset
enable  input  1  count enable; 0 freezes counter and state (pause)
start  input  1  pulse: (re)load counter and enter RUN
stop  input  1  pulse: return to IDLE
one_shot  input  1  1 = return to IDLE after the first tick; sampled on start
rate_sel  input  SEL_W  period select, normal period = BASE_PERIOD << rate_sel
fast  input  1  soft-drop override
tick  output  1  registered single-cycle pulse
busy  output  1  1 while in RUN
tick_count  output  TCNT_W  ticks since clear, wraps
period  output  CNT_W  current effective period (combinational)

Behaviour:
- Period arithmetic: P_norm = BASE_PERIOD << rate_sel, computed at CNT_W+2^SEL_W bits, saturated to 2^CNT_W-1 on overflow. P = fast ? min(FAST_PERIOD, P_norm) : P_norm. period = P. Load value L = P-1.
- States: IDLE, RUN. Registers: count[CNT_W], mode_os, tick, tick_count, fast_q (previous fast).
- clear=1: state=IDLE, count=0, tick=0, tick_count=0, mode_os=0, fast_q=0. busy=0. clear overrides all other inputs in the same cycle.
- Priority each edge, with clear=0: stop > start > fast-rise > count. All of these act regardless of enable. Only decrement and tick generation require enable=1.
- stop=1: go to IDLE, tick<=0, count held. stop and start in the same cycle: stop wins.
- start=1 (IDLE or RUN): go to RUN, count<=L, mode_os<=one_shot, tick<=0. Restart in RUN discards the partial period and produces no tick.
- RUN, fast rising (fast=1, fast_q=0): count<=min(count, L). Soft-drop reacts within the current period, never lengthens it. A fast falling edge does not reload; the new period applies at the next reload.
- RUN, enable=1, count!=0: count<=count-1, tick<=0.
- RUN, enable=1, count==0: tick<=1, tick_count<=tick_count+1 (wraps 2^TCNT_W-1 -> 0), count<=L using the current P (rate_sel changes take effect here). If mode_os=1, go to IDLE.
- RUN, enable=0: count, state and tick_count held; tick<=0.
- IDLE: tick<=0, count held, no counting.
- fast_q<=fast every non-clear cycle.
- Timing: start sampled at edge 0 with enable held 1. tick is high in the cycle following edge P, then every P cycles. P=1 gives tick every cycle from edge 1.
- tick is never high for two cycles unless P=1.
- busy is registered state==RUN; it drops in the same cycle tick rises on a one-shot.

Test Plan:
(Test params: CNT_W=8, BASE_PERIOD=4, FAST_PERIOD=2, SEL_W=2, TCNT_W=2.)
1. clear, then start with rate_sel=0, one_shot=0, enable=1 -> tick high after edges 4, 8, 12, 16, 20. tick_count reads 1, 2, 3, 0, 1 (wrap). busy=1 throughout.
2. rate_sel=2 (P=16) then start; drop enable for 5 cycles mid-period -> first tick after edge 21, not 16. tick stays low during the pause.
3. BASE_PERIOD=100 instance, rate_sel=2 -> period=255 (saturated). Ticks spaced 255 cycles.
4. rate_sel=3 (P=32), start; raise fast at edge 10 -> count reloads to 1, tick after edge 12, then every 2 cycles. Drop fast -> next reload uses 32.
5. one_shot=1, start -> single tick after edge 4, busy=0 from edge 4, no further ticks. start and stop asserted together -> stays IDLE, busy=0.
6. clear asserted mid-period in RUN -> tick=0, busy=0, tick_count=0 on the next cycle. No ticks until the next start.
